// File: rtl/cic_decimator_slice.sv
// Decimating CIC filter (N integrators, N combs, M=1) for one I/Q leg of the tuner output.
// Optional round-half-up on the output slice when CIC_ROUND_EN is defined; otherwise plain truncation.
module cic_decimator_slice #(
  parameter int isz   = 14,
  parameter int osz   = 16,
  parameter int nstg  = 4,
  parameter int rlog2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [isz-1:0] in,
  input  logic                  in_valid,
  output logic signed [osz-1:0] out,
  output logic                  out_valid
);

  localparam int bsz = isz + nstg * rlog2;

`ifdef CIC_ROUND_EN
  localparam logic round_en = 1'b1;
`else
  localparam logic round_en = 1'b0;
`endif

  logic [bsz-1:0]   x_ext;
  logic [bsz-1:0]   integ_reg  [nstg];
  logic [bsz-1:0]   integ_next [nstg];
  logic [rlog2-1:0] cnt_reg;
  logic             wrap;

  // comb_reg[0] is the decimated integrator sample; comb_reg[k] is the output of comb stage k
  logic [bsz-1:0]   comb_reg [nstg+1];
  logic [bsz-1:0]   dly_reg  [nstg];
  logic [nstg:0]    v_reg;

  logic signed [osz:0]   top;
  logic signed [osz:0]   scaled;
  logic signed [osz-1:0] sat;

  assign x_ext = {{(bsz-isz){in[isz-1]}}, in};
  assign wrap  = in_valid && (cnt_reg == {rlog2{1'b1}});

  // Each integrator adds the registered value of the stage before it; modulo-2^bsz wrap is intended.
  always_comb begin
    integ_next[0] = integ_reg[0] + x_ext;
    for (int k = 1; k < nstg; k++) begin
      integ_next[k] = integ_reg[k] + integ_reg[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < nstg; k++) begin
        integ_reg[k] <= '0;
      end
      cnt_reg <= '0;
    end else if (in_valid) begin
      for (int k = 0; k < nstg; k++) begin
        integ_reg[k] <= integ_next[k];
      end
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_reg <= '0;
      for (int k = 0; k <= nstg; k++) begin
        comb_reg[k] <= '0;
      end
      for (int k = 0; k < nstg; k++) begin
        dly_reg[k] <= '0;
      end
    end else begin
      v_reg[0] <= wrap;
      if (wrap) begin
        comb_reg[0] <= integ_next[nstg-1];
      end
      for (int k = 1; k <= nstg; k++) begin
        v_reg[k] <= v_reg[k-1];
        if (v_reg[k-1]) begin
          comb_reg[k]  <= comb_reg[k-1] - dly_reg[k-1];
          dly_reg[k-1] <= comb_reg[k-1];
        end
      end
    end
  end

  // Slice one bit below the output LSB; (t+1)>>1 == (t>>1) + t[0] gives round-half-up
  assign top    = comb_reg[nstg][bsz-1 -: osz+1];
  assign scaled = {top[osz], top[osz:1]} + {{osz{1'b0}}, top[0] & round_en};

  always_comb begin
    sat = scaled[osz-1:0];
    if (scaled[osz] != scaled[osz-1]) begin
      sat = scaled[osz] ? {1'b1, {(osz-1){1'b0}}} : {1'b0, {(osz-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= v_reg[nstg];
      if (v_reg[nstg]) begin
        out <= sat;
      end
    end
  end

endmodule

// File: tb/tb_cic_decimator_slice.sv
// Scoreboard bench for cic_decimator_slice: arithmetic reference model, value + cycle checks per output.
module tb_cic_decimator_slice;

  localparam int ISZ  = 14;
  localparam int OSZ  = 16;
  localparam int BSZ  = 38;
  localparam int R    = 64;
  localparam int DROP = BSZ - OSZ;

  logic                  clk = 1'b0;
  logic                  reset;
  logic signed [ISZ-1:0] in_s;
  logic                  in_valid;
  logic signed [OSZ-1:0] out;
  logic                  out_valid;

  cic_decimator_slice dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_s),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     val;
    longint exp_cyc;
    bit     dc_en;
    int     dc_val;
  } exp_t;

  exp_t   sbq[$];
  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;
  int     nseen = 0;
  bit     prev_v = 1'b0;

  always @(posedge clk) cyc++;

  // Reference model state: integrators, comb delays, accepted-sample and output counts
  longint m_int[4];
  longint m_dly[4];
  int     m_nacc;
  int     m_nout;

  function automatic longint sx(input longint v);
    longint w;
    w = v & ((longint'(1) << BSZ) - 1);
    if (w[BSZ-1]) return w - (longint'(1) << BSZ);
    return w;
  endfunction

  function automatic int scale(input longint c);
    longint r;
`ifdef CIC_ROUND_EN
    r = (c + (longint'(1) << (DROP-1))) >>> DROP;
`else
    r = c >>> DROP;
`endif
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_int[k] = 0;
      m_dly[k] = 0;
    end
    m_nacc = 0;
    m_nout = 0;
  endtask

  // One clock of stimulus; accepted samples advance the model and queue an expectation every R samples
  task automatic step(input int x, input bit v, input bit dc_en, input int dc_val);
    longint nw[4];
    longint y;
    longint t;
    exp_t   e;
    @(negedge clk);
    in_s     = x[ISZ-1:0];
    in_valid = v;
    if (v) begin
      nw[0] = sx(m_int[0] + longint'(x));
      for (int k = 1; k < 4; k++) nw[k] = sx(m_int[k] + m_int[k-1]);
      m_int = nw;
      m_nacc++;
      if (m_nacc % R == 0) begin
        y = nw[3];
        for (int k = 0; k < 4; k++) begin
          t        = sx(y - m_dly[k]);
          m_dly[k] = y;
          y        = t;
        end
        m_nout++;
        e.val     = scale(y);
        e.exp_cyc = cyc + 6;
        e.dc_en   = dc_en && (m_nout >= 5);
        e.dc_val  = dc_val;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    model_reset();
    #1;
    chk("reset_out", out, 0);
    chk("reset_out_valid", out_valid, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(16383)) - 8192;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid) begin
        nseen++;
        $display("out #%0d cyc=%0d val=%0d", nseen, cyc, out);
        chk("out_valid_back_to_back", prev_v, 0);
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0d expected no output", out);
        end else begin
          e = sbq.pop_front();
          chk("out_value", out, e.val);
          chk("out_cycle", cyc, e.exp_cyc);
          if (e.dc_en) chk("dc_settled", out, e.dc_val);
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_s     = '0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    chk("por_out", out, 0);
    chk("por_out_valid", out_valid, 0);

    // DC 1000, every clock
    do_reset();
    repeat (R*8) step(1000, 1'b1, 1'b1, 4000);
    idle(10);

    // Negative and positive full scale
    do_reset();
    repeat (R*7) step(-8192, 1'b1, 1'b1, -32768);
    idle(10);
    do_reset();
    repeat (R*7) step(8191, 1'b1, 1'b1, 32764);
    idle(10);

    // DC 1000 with in_valid toggling; gap cycles carry junk data
    do_reset();
    repeat (R*7) begin
      step(1000, 1'b1, 1'b1, 4000);
      step(rnd_sample(), 1'b0, 1'b0, 0);
    end
    idle(10);

    // Alternating full-scale extremes: integrators wrap many times
    do_reset();
    for (int i = 0; i < 10000; i++) step((i % 2 == 0) ? 8191 : -8192, 1'b1, 1'b1, -2);
    idle(10);

    // Reset mid-burst after 30 samples, then restart
    do_reset();
    repeat (30) step(rnd_sample(), 1'b1, 1'b0, 0);
    do_reset();
    repeat (R*4) step(rnd_sample(), 1'b1, 1'b0, 0);

    // Random data with random gaps, reset while outputs are flowing
    do_reset();
    repeat (1500) step(rnd_sample(), ($urandom_range(3) != 0), 1'b0, 0);
    do_reset();
    repeat (1500) step(rnd_sample(), ($urandom_range(3) != 0), 1'b0, 0);

    n = 0;
    while (sbq.size() != 0 && n < 400) begin
      idle(1);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
